// File: rtl/efuse_rd_timing_if.sv
// Controller-side request/response bundle for the efuse read timing engine.
interface efuse_rd_timing_if #(parameter int NR = 64);
   localparam int SEL_W = (256 / NR > 1) ? $clog2(256 / NR) : 1;

   logic             read_start;
   logic [SEL_W-1:0] efuse_read_sel;
   logic             read_done;
   logic [NR-1:0]    read_data;
   logic             efuse_busy_read;
   logic             rd_mismatch;

   modport master (
      output read_start, efuse_read_sel,
      input  read_done, read_data, efuse_busy_read, rd_mismatch
   );

   modport slave (
      input  read_start, efuse_read_sel,
      output read_done, read_data, efuse_busy_read, rd_mismatch
   );
endinterface

// File: rtl/efuse_rd_timing.sv
// Efuse macro read sequencer: SETUP/STROBE/HOLD per byte, assembles NR-bit segment.
// Optional EFUSE_RD_VERIFY_EN strobes every byte twice and flags any capture difference.
module efuse_rd_timing #(
   parameter int NR       = 64,
   parameter int T_SETUP  = 2,
   parameter int T_STROBE = 4,
   parameter int T_HOLD   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   efuse_rd_timing_if.slave   bus,
   output logic               efuse_csb,
   output logic               efuse_strobe,
   output logic               efuse_load,
   output logic               efuse_pgenb,
   output logic [4:0]         efuse_addr,
   input  logic [7:0]         efuse_q
);
   localparam int WPR   = NR / 8;
   localparam int SEL_W = (256 / NR > 1) ? $clog2(256 / NR) : 1;
   localparam int WC_W  = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int TMR_W = 16;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic [NR-1:0]    data_q, data_d;
   logic             csb_q, csb_d, strobe_q, strobe_d, load_q, load_d;
   logic             pgenb_q, done_q, done_d, busy_q, busy_d;
   logic [4:0]       addr_q, addr_d;
   logic             act, again;
`ifdef EFUSE_RD_VERIFY_EN
   logic             pass_q, pass_d, mism_q, mism_d;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      wcnt_d  = wcnt_q;
      data_d  = data_q;
      again   = 1'b0;
`ifdef EFUSE_RD_VERIFY_EN
      pass_d  = pass_q;
      mism_d  = mism_q;
`endif
      case (state_q)
         IDLE: if (bus.read_start) begin
            state_d = SETUP;
            sel_d   = bus.efuse_read_sel;
            wcnt_d  = '0;
            data_d  = '0;
`ifdef EFUSE_RD_VERIFY_EN
            pass_d  = 1'b0;
            mism_d  = 1'b0;
`endif
         end
         SETUP: if (tmr_q == TMR_W'(T_SETUP - 1)) state_d = STROBE;
         STROBE: if (tmr_q == TMR_W'(T_STROBE - 1)) begin
            state_d = HOLD;
`ifdef EFUSE_RD_VERIFY_EN
            // Second pass only compares; the stored byte is always the first capture.
            if (pass_q) begin
               if (data_q[8*wcnt_q +: 8] != efuse_q) mism_d = 1'b1;
            end else begin
               data_d[8*wcnt_q +: 8] = efuse_q;
            end
`else
            data_d[8*wcnt_q +: 8] = efuse_q;
`endif
         end
         HOLD: if (tmr_q == TMR_W'(T_HOLD - 1)) begin
`ifdef EFUSE_RD_VERIFY_EN
            again  = !pass_q;
            pass_d = !pass_q;
`endif
            if (again)                             state_d = STROBE;
            else if (wcnt_q != WC_W'(WPR - 1)) begin
               wcnt_d  = wcnt_q + 1'b1;
               state_d = SETUP;
            end else                               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
      if (state_d != state_q) tmr_d = '0;

      // Outputs decoded from next state so the registered pins line up with state_q.
      act      = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      csb_d    = !act;
      load_d   = act;
      strobe_d = (state_d == STROBE);
      addr_d   = act ? (5'(sel_d) * 5'(WPR) + 5'(wcnt_d)) : 5'd0;
      done_d   = (state_d == DONE);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tmr_q    <= '0;
         sel_q    <= '0;
         wcnt_q   <= '0;
         data_q   <= '0;
         csb_q    <= 1'b1;
         strobe_q <= 1'b0;
         load_q   <= 1'b0;
         pgenb_q  <= 1'b1;
         addr_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef EFUSE_RD_VERIFY_EN
         pass_q   <= 1'b0;
         mism_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         sel_q    <= sel_d;
         wcnt_q   <= wcnt_d;
         data_q   <= data_d;
         csb_q    <= csb_d;
         strobe_q <= strobe_d;
         load_q   <= load_d;
         pgenb_q  <= 1'b1;
         addr_q   <= addr_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef EFUSE_RD_VERIFY_EN
         pass_q   <= pass_d;
         mism_q   <= mism_d;
`endif
      end
   end

   assign efuse_csb           = csb_q;
   assign efuse_strobe        = strobe_q;
   assign efuse_load          = load_q;
   assign efuse_pgenb         = pgenb_q;
   assign efuse_addr          = addr_q;
   assign bus.read_done       = done_q;
   assign bus.read_data       = data_q;
   assign bus.efuse_busy_read = busy_q;
`ifdef EFUSE_RD_VERIFY_EN
   assign bus.rd_mismatch     = mism_q;
`else
   assign bus.rd_mismatch     = 1'b0;
`endif
endmodule

// File: doc/efuse_rd_timing.md
EFUSE_RD_TIMING -- requirements
Module: efuse_rd_timing

Interface
REQ-001 Parameter: NR, default 64, read width in bits per request; SHALL be a multiple of 8 that divides 256.
REQ-002 Parameter: T_SETUP, default 2, cycles from address/CSB/LOAD valid to STROBE rise; SHALL be at least 1.
REQ-003 Parameter: T_STROBE, default 4, STROBE high width in cycles; SHALL be at least 1.
REQ-004 Parameter: T_HOLD, default 1, cycles from STROBE fall to the next address change or DONE; SHALL be at least 1.
REQ-005 clk  input  1  single clock; all flops rise-edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 read_start  input  1  one-cycle request pulse from the efuse controller.
REQ-008 efuse_read_sel  input  $clog2(256/NR)  selects the NR-bit segment to read.
REQ-009 read_done  output  1  one-cycle completion pulse.
REQ-010 read_data  output  NR  assembled read result.
REQ-011 efuse_busy_read  output  1  engine active.
REQ-012 efuse_csb / efuse_strobe / efuse_load / efuse_pgenb  output  1 each  macro controls.
REQ-013 efuse_addr  output  5  macro byte address (32 words x 8 bits).
REQ-014 efuse_q  input  8  macro read data.
REQ-015 rd_mismatch  output  1  sticky double-read mismatch flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, DONE.
REQ-017 IDLE->SETUP on read_start; the engine SHALL latch efuse_read_sel and clear word_cnt and read_data.
REQ-018 read_start in any state other than IDLE SHALL be ignored, with no effect on the current read.
REQ-019 efuse_addr SHALL equal sel*(NR/8)+word_cnt, a 5-bit result, held constant from SETUP entry through the end of HOLD.
REQ-020 SETUP SHALL last T_SETUP cycles, then go to STROBE.
REQ-021 STROBE SHALL last T_STROBE cycles with efuse_strobe=1; on the last STROBE cycle, efuse_q SHALL be captured into read_data[8*word_cnt+7 : 8*word_cnt].
REQ-022 HOLD SHALL last T_HOLD cycles.
- If word_cnt < NR/8-1: word_cnt increments, next state SETUP.
- Otherwise: next state DONE.
REQ-023 DONE SHALL last 1 cycle with read_done=1, then go to IDLE.
REQ-024 read_data SHALL remain stable from DONE until the next accepted read_start.
REQ-025 In SETUP, STROBE and HOLD: efuse_csb=0, efuse_load=1, efuse_pgenb=1.
REQ-026 In IDLE and DONE: efuse_csb=1, efuse_load=0, efuse_strobe=0, efuse_pgenb=1, efuse_addr=0.
REQ-027 efuse_busy_read SHALL be 1 in every non-IDLE state, including DONE.
REQ-028 All macro control outputs and read_done SHALL be driven from flops, glitch-free.
REQ-029 Timing counters SHALL saturate and reset on every state change.
REQ-030 Latency at defaults without the Configuration macro: read_start accepted in cycle 0 -> read_done in cycle 57 (1 + 8 words x 7 cycles).

Reset
REQ-031 While rst_n=0: state=IDLE, read_data=0, read_done=0, efuse_busy_read=0, rd_mismatch=0, and macro outputs at the IDLE values of REQ-026, all immediately.
REQ-032 Reset asserted mid-read SHALL abort the read with no read_done; the first read_start after release SHALL start a fresh read.

Configuration
REQ-033 With macro EFUSE_RD_VERIFY_EN defined, each word SHALL be strobed twice (SETUP, STROBE, HOLD, STROBE, HOLD).
- The first capture is stored.
- The second capture is compared; any difference sets rd_mismatch.
- rd_mismatch is sticky until the next accepted read_start or reset.
- Default latency becomes 97 cycles.
REQ-034 Without EFUSE_RD_VERIFY_EN, each word SHALL be strobed once and rd_mismatch SHALL be tied to 0.

Verification
REQ-035 Defaults, model returns q=addr+8'hA0, read_start with sel=2 -> addresses 16..23 in order, read_data=64'hB7B6B5B4B3B2B1B0, read_done in cycle 57.
REQ-036 Check on every word: STROBE high exactly 4 cycles; CSB low at least 2 cycles before STROBE rise; address stable until 1 cycle after STROBE fall.
REQ-037 read_start repeated in cycles 5 and 40 of a read -> ignored, exactly one read_done, busy continuous from cycle 1 to cycle 57.
REQ-038 rst_n pulsed low in cycle 20 -> outputs immediately at IDLE values with no read_done; a new read with sel=0 completes correctly.
REQ-039 With EFUSE_RD_VERIFY_EN, model flips bit 3 on the second strobe of address 5 with sel=0 -> rd_mismatch=1 at read_done, read_data byte 5 holds the first capture, read_done in cycle 97.
REQ-040 With EFUSE_RD_VERIFY_EN, a clean second read -> rd_mismatch clears on read_start and stays 0.
